// File: rtl/myproject_mul_sched_10ns_9ns_18.sv
// Shared-multiplier scheduler.
// Round-robin arbitration of NUM_REQ requesters onto one unsigned A_W x B_W
// multiplier. The product passes through MUL_LAT register stages and is
// returned with its requester ID through a first-word-fall-through queue.
// Issue is credit-based, so the queue can never overflow.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   synchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_a      packed operand A, requester i at [i*A_W +: A_W]
//   req_b      packed operand B, requester i at [i*B_W +: B_W]
//   res_valid  result queue non-empty
//   res_ready  downstream accepts head result
//   res_data   product at queue head (0 when empty)
//   res_id     requester index at queue head (0 when empty)
//   busy       any product in pipeline or queue
module myproject_mul_sched_10ns_9ns_18 #(
    parameter  int NUM_REQ    = 4,
    parameter  int A_W        = 10,
    parameter  int B_W        = 9,
    parameter  int P_W        = 18,
    parameter  int MUL_LAT    = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [P_W-1:0]         res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = A_W + B_W;

    logic [ID_W-1:0] rr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand_idx;
    int              cand;
    logic            issue;
    logic            pop;

    logic [A_W-1:0]  sel_a;
    logic [B_W-1:0]  sel_b;
    logic [FW-1:0]   full_prod;

    logic [MUL_LAT-1:0] pipe_vld;
    logic [P_W-1:0]     pipe_data [MUL_LAT];
    logic [ID_W-1:0]    pipe_id   [MUL_LAT];

    logic [P_W-1:0]  q_data [FIFO_DEPTH];
    logic [ID_W-1:0] q_id   [FIFO_DEPTH];
    logic            q_wr;

    // Search starts one past the last grant and wraps modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // count is registered: a pop this cycle frees its credit next cycle.
    assign issue = ap_rst_n && grant_found && (count < CW'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[grant_idx] = 1'b1;
    end

    assign sel_a     = req_a[grant_idx*A_W +: A_W];
    assign sel_b     = req_b[grant_idx*B_W +: B_W];
    assign full_prod = FW'(sel_a) * FW'(sel_b);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int s = 1; s < MUL_LAT; s++) pipe_vld[s] <= pipe_vld[s-1];
        end
    end

    // Datapath registers need no reset; the valid tags qualify them.
    always_ff @(posedge ap_clk) begin
        pipe_data[0] <= full_prod[P_W-1:0];
        pipe_id[0]   <= grant_idx;
        for (int s = 1; s < MUL_LAT; s++) begin
            pipe_data[s] <= pipe_data[s-1];
            pipe_id[s]   <= pipe_id[s-1];
        end
    end

    assign q_wr      = pipe_vld[MUL_LAT-1];
    assign res_valid = (wr_ptr != rd_ptr);
    assign pop       = res_valid && res_ready;

    always_ff @(posedge ap_clk) begin
        if (q_wr) begin
            q_data[wr_ptr[AW-1:0]] <= pipe_data[MUL_LAT-1];
            q_id[wr_ptr[AW-1:0]]   <= pipe_id[MUL_LAT-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else begin
            if (q_wr) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            if (issue && !pop)      count <= count + CW'(1);
            else if (!issue && pop) count <= count - CW'(1);
            if (issue) rr_ptr <= grant_idx;
        end
    end

    assign res_data = res_valid ? q_data[rd_ptr[AW-1:0]] : '0;
    assign res_id   = res_valid ? q_id[rd_ptr[AW-1:0]]   : '0;
    assign busy     = (count != '0);

endmodule

// File: tb/tb_myproject_mul_sched_10ns_9ns_18.sv
module tb_myproject_mul_sched_10ns_9ns_18;

    localparam int NUM_REQ = 4;
    localparam int A_W     = 10;
    localparam int B_W     = 9;
    localparam int P_W     = 18;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [P_W-1:0]         res_data;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    logic [A_W-1:0] a_v [NUM_REQ];
    logic [B_W-1:0] b_v [NUM_REQ];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*A_W +: A_W] = a_v[i];
            req_b[i*B_W +: B_W] = b_v[i];
        end
    end

    myproject_mul_sched_10ns_9ns_18 dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic [A_W+B_W-1:0] f;
        f = (A_W+B_W)'(a) * (A_W+B_W)'(b);
        return f[P_W-1:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check req_ready against the expected grant and, on a grant,
    // queue the expected result for the monitor.
    task automatic cyc(input logic [NUM_REQ-1:0] exp_rdy, input string nm);
        exp_t e;
        @(negedge clk);
        check(nm, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i]) begin
                e.id   = ID_W'(i);
                e.data = ref_mul(a_v[i], b_v[i]);
                sb.push_back(e);
            end
        end
        tick();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id %0d data %0d expected none", res_id, res_data);
                end else begin
                    e = sb.pop_front();
                    check("res_id", 32'(res_id), 32'(e.id));
                    check("res_data", 32'(res_data), 32'(e.data));
                end
            end
            if (!res_valid) begin
                check("idle_data_zero", 32'(res_data), 32'd0);
                check("idle_id_zero", 32'(res_id), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        logic [NUM_REQ-1:0] oh;

        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset state, requesters valid to show req_ready is forced low
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single op: requester 2, 25*17 = 425
        a_v[2] = 10'd25;
        b_v[2] = 9'd17;
        req_valid = 4'b0100;
        cyc(4'b0100, "single_grant");
        req_valid = '0;
        check("single_c1_valid", 32'(res_valid), 32'd0);
        check("single_c1_busy", 32'(busy), 32'd1);
        tick();
        check("single_c2_valid", 32'(res_valid), 32'd1);
        check("single_c2_data", 32'(res_data), 32'd425);
        check("single_c2_id", 32'(res_id), 32'd2);
        check("single_c2_busy", 32'(busy), 32'd1);
        tick();
        check("single_c3_busy", 32'(busy), 32'd0);
        check("single_c3_valid", 32'(res_valid), 32'd0);

        // Truncation: 1023*511 = 522753 -> 260609; then 0*511 = 0
        a_v[0] = 10'd1023;
        b_v[0] = 9'd511;
        req_valid = 4'b0001;
        cyc(4'b0001, "trunc_grant_a");
        a_v[0] = 10'd0;
        cyc(4'b0001, "trunc_grant_b");
        req_valid = '0;
        check("trunc_valid", 32'(res_valid), 32'd1);
        check("trunc_data", 32'(res_data), 32'd260609);
        check("trunc_id", 32'(res_id), 32'd0);
        tick();
        check("zero_valid", 32'(res_valid), 32'd1);
        check("zero_data", 32'(res_data), 32'd0);
        drain(2);

        // Round-robin: last grant was 0, so order is 1,2,3,0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = 10'(50 * (i + 1) + 3);
            b_v[i] = 9'(100 * i + 7);
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            oh = '0;
            oh[rr_order[k]] = 1'b1;
            cyc(oh, "rr_grant");
        end
        req_valid = '0;
        drain(4);
        check("rr_drained_busy", 32'(busy), 32'd0);

        // Backpressure: four credits, then full; one pop frees one issue
        res_ready = 1'b0;
        req_valid = 4'b0010;
        b_v[1]    = 9'd3;
        for (int k = 0; k < 4; k++) begin
            a_v[1] = 10'(100 + k);
            cyc(4'b0010, "bp_fill");
        end
        a_v[1] = 10'd200;
        cyc(4'b0000, "bp_full");
        cyc(4'b0000, "bp_full");
        res_ready = 1'b1;
        cyc(4'b0000, "bp_pop_cycle");
        res_ready = 1'b0;
        cyc(4'b0010, "bp_refill");
        a_v[1] = 10'd201;
        cyc(4'b0000, "bp_full_again");
        req_valid = '0;
        res_ready = 1'b1;
        drain(8);

        // Stall stability: requester 3 waits on exhausted credits
        res_ready = 1'b0;
        req_valid = 4'b0001;
        b_v[0]    = 9'd2;
        for (int k = 0; k < 4; k++) begin
            a_v[0] = 10'(k + 1);
            cyc(4'b0001, "stall_fill");
        end
        a_v[3] = 10'd777;
        b_v[3] = 9'd300;
        req_valid = 4'b1000;
        cyc(4'b0000, "stall_wait");
        cyc(4'b0000, "stall_wait");
        res_ready = 1'b1;
        cyc(4'b0000, "stall_pop_cycle");
        res_ready = 1'b0;
        cyc(4'b1000, "stall_grant3");
        req_valid = '0;
        res_ready = 1'b1;
        drain(8);

        // Reset mid-operation with three products outstanding
        res_ready = 1'b0;
        req_valid = 4'b0100;
        b_v[2]    = 9'd5;
        for (int k = 0; k < 3; k++) begin
            a_v[2] = 10'(k + 9);
            cyc(4'b0100, "rstmid_fill");
        end
        a_v[0] = 10'd12;
        b_v[0] = 9'd12;
        a_v[3] = 10'd13;
        b_v[3] = 9'd13;
        req_valid = 4'b1001;
        rst_n     = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rstmid_ready_low", 32'(req_ready), 32'd0);
        tick();
        check("rstmid_res_valid", 32'(res_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        cyc(4'b0001, "rstmid_first_grant");
        req_valid = '0;
        drain(4);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
